// File: rtl/alu_reg_pkg.sv
// Shared constants for the register-file/ALU datapath: effective opcodes,
// flag bit positions and the select value at which a bus or write is disabled.
package alu_reg_pkg;

  localparam int IDX_W = 4;
  localparam logic [4:0] SEL_DISABLE = 5'd16;

  localparam logic [3:0] EC_AND  = 4'b0001;
  localparam logic [3:0] EC_OR   = 4'b0010;
  localparam logic [3:0] EC_XOR  = 4'b0011;
  localparam logic [3:0] EC_ADD  = 4'b0101;
  localparam logic [3:0] EC_ADDU = 4'b0110;
  localparam logic [3:0] EC_ADDC = 4'b0111;
  localparam logic [3:0] EC_LSH  = 4'b1000;
  localparam logic [3:0] EC_SUB  = 4'b1001;
  localparam logic [3:0] EC_SUBC = 4'b1010;
  localparam logic [3:0] EC_CMP  = 4'b1011;
  localparam logic [3:0] EC_MOV  = 4'b1101;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, next flags and write/flag-update qualifiers.
// Define ALU_SHIFT_EN to enable the LSH opcode; otherwise it decodes as NOP.
module alu_core
  import alu_reg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       ec,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags_next,
  output logic             write_valid,
  output logic             flags_valid
);

  logic [WIDTH:0] sum, diff;
  logic           add_cin, sub_cin, add_ovf, sub_ovf, is_sub;

  assign add_cin = (ec == EC_ADDC) & cin;
  assign sub_cin = (ec == EC_SUBC) & cin;
  assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
  // bit WIDTH of the difference is the borrow out
  assign diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  assign is_sub  = (ec == EC_SUB) || (ec == EC_SUBC) || (ec == EC_CMP);

`ifdef ALU_SHIFT_EN
  logic [4:0] shr;
  // magnitude of a negative 5-bit amount; -16 gives 16, shifting everything out
  assign shr = 5'(~b[4:0] + 5'd1);
`endif

  always_comb begin
    result      = '0;
    flags_next  = '0;
    write_valid = 1'b1;
    flags_valid = 1'b1;
    case (ec)
      EC_AND: result = a & b;
      EC_OR:  result = a | b;
      EC_XOR: result = a ^ b;
      EC_ADD, EC_ADDC: begin
        result             = sum[WIDTH-1:0];
        flags_next[FLAG_C] = sum[WIDTH];
        flags_next[FLAG_F] = add_ovf;
      end
      EC_ADDU: begin
        result             = sum[WIDTH-1:0];
        flags_next[FLAG_C] = sum[WIDTH];
      end
      EC_SUB, EC_SUBC, EC_CMP: begin
        result             = diff[WIDTH-1:0];
        flags_next[FLAG_C] = diff[WIDTH];
        flags_next[FLAG_F] = sub_ovf;
        flags_next[FLAG_L] = a < b;
        write_valid        = (ec != EC_CMP);
      end
      EC_MOV: result = b;
`ifdef ALU_SHIFT_EN
      EC_LSH: result = b[4] ? (a >> shr) : (a << b[3:0]);
`endif
      default: begin
        write_valid = 1'b0;
        flags_valid = 1'b0;
      end
    endcase
    // subtract family reports the comparison, not the result
    if (is_sub) begin
      flags_next[FLAG_Z] = (a == b);
      flags_next[FLAG_N] = $signed(a) < $signed(b);
    end else begin
      flags_next[FLAG_Z] = (result == '0);
      flags_next[FLAG_N] = result[WIDTH-1];
    end
  end

endmodule

// File: rtl/alu_reg_integration.sv
// Register file + ALU + flag register datapath with single-cycle write-back.
// Optional LSH opcode lives in alu_core behind ALU_SHIFT_EN.
module alu_reg_integration
  import alu_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] immediate,
  input  logic [4:0]       regEnables,
  input  logic [4:0]       buffAEnables,
  input  logic [4:0]       buffBEnables,
  input  logic             Cin,
  input  logic             regOrImmed,
  input  logic [3:0]       op,
  input  logic [3:0]       exop,
  output logic [4:0]       flagsOutput,
  output logic [WIDTH-1:0] regOut15
);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [4:0]       flags, flags_next;
  logic [WIDTH-1:0] bus_a, bus_b, opnd_b, result;
  logic [3:0]       ec;
  logic             write_valid, flags_valid, wr_en;

  assign ec     = (op == 4'b0000) ? exop : op;
  assign bus_a  = (buffAEnables >= SEL_DISABLE) ? '0 : regs[buffAEnables[IDX_W-1:0]];
  assign bus_b  = (buffBEnables >= SEL_DISABLE) ? '0 : regs[buffBEnables[IDX_W-1:0]];
  assign opnd_b = regOrImmed ? bus_b : immediate;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a           (bus_a),
    .b           (opnd_b),
    .cin         (Cin),
    .ec          (ec),
    .result      (result),
    .flags_next  (flags_next),
    .write_valid (write_valid),
    .flags_valid (flags_valid)
  );

  assign wr_en = write_valid && (regEnables < SEL_DISABLE);

  // reads above see the pre-edge contents, so same-register ops are read-before-write
  always_ff @(posedge clock) begin
    if (reset) begin
      regs  <= '0;
      flags <= '0;
    end else begin
      if (wr_en)       regs[regEnables[IDX_W-1:0]] <= result;
      if (flags_valid) flags <= flags_next;
    end
  end

  assign flagsOutput = flags;
  assign regOut15    = regs[NREGS-1];

endmodule

// File: tb/tb_alu_reg_integration.sv
// Directed table-driven bench for alu_reg_integration; observes r15 and flags
// {N,Z,F,L,C} one edge after each applied vector.
module tb_alu_reg_integration;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] immediate;
  logic [4:0]  regEnables, buffAEnables, buffBEnables;
  logic        Cin, regOrImmed;
  logic [3:0]  op, exop;
  logic [4:0]  flagsOutput;
  logic [15:0] regOut15;

  int checks = 0;
  int errors = 0;

  alu_reg_integration dut (
    .clock        (clock),
    .reset        (reset),
    .immediate    (immediate),
    .regEnables   (regEnables),
    .buffAEnables (buffAEnables),
    .buffBEnables (buffBEnables),
    .Cin          (Cin),
    .regOrImmed   (regOrImmed),
    .op           (op),
    .exop         (exop),
    .flagsOutput  (flagsOutput),
    .regOut15     (regOut15)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [15:0] imm;
    logic [4:0]  regen, aen, ben;
    logic        cin, roi;
    logic [3:0]  op, exop;
    logic [15:0] exp_r15;
    logic [4:0]  exp_flags;   // {N,Z,F,L,C}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [15:0] imm,
                              input logic [4:0] regen, input logic [4:0] aen,
                              input logic [4:0] ben, input logic cin, input logic roi,
                              input logic [3:0] opc, input logic [3:0] exopc,
                              input logic [15:0] r15, input logic [4:0] flg);
    vec_t v;
    v.rst = rst; v.imm = imm; v.regen = regen; v.aen = aen; v.ben = ben;
    v.cin = cin; v.roi = roi; v.op = opc; v.exop = exopc;
    v.exp_r15 = r15; v.exp_flags = flg;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] r15, input logic [4:0] flg);
    checks++;
    if (regOut15 !== r15) begin
      errors++;
      $display("FAIL %s r15: got %h want %h", name, regOut15, r15);
    end
    checks++;
    if (flagsOutput !== flg) begin
      errors++;
      $display("FAIL %s flags: got %b want %b", name, flagsOutput, flg);
    end
  endtask

  initial begin
    //            rst imm       regen  aen    ben    cin roi op       exop     r15       NZFLC
    vecs.push_back(mk(0, 16'h0001, 5'd15, 5'd15, 5'd0,  0, 0, 4'b0011, 4'b0000, 16'h0001, 5'b00000)); // XOR
    vecs.push_back(mk(0, 16'hFFFF, 5'd1,  5'd0,  5'd0,  0, 0, 4'b0000, 4'b1101, 16'h0001, 5'b10000)); // MOV r1
    vecs.push_back(mk(0, 16'h0001, 5'd15, 5'd1,  5'd0,  0, 0, 4'b0101, 4'b0000, 16'h0000, 5'b01001)); // ADD carry
    vecs.push_back(mk(0, 16'h7FFF, 5'd15, 5'd0,  5'd0,  0, 0, 4'b1101, 4'b0000, 16'h7FFF, 5'b00000)); // MOV
    vecs.push_back(mk(0, 16'h0001, 5'd15, 5'd15, 5'd0,  0, 0, 4'b0101, 4'b0000, 16'h8000, 5'b10100)); // ADD ovf
    vecs.push_back(mk(0, 16'h0005, 5'd15, 5'd0,  5'd0,  0, 0, 4'b1101, 4'b0000, 16'h0005, 5'b00000)); // MOV 5
    vecs.push_back(mk(0, 16'h0007, 5'd15, 5'd15, 5'd0,  0, 0, 4'b1011, 4'b0000, 16'h0005, 5'b10011)); // CMP 5,7
    vecs.push_back(mk(0, 16'h0005, 5'd15, 5'd15, 5'd0,  0, 0, 4'b1011, 4'b0000, 16'h0005, 5'b01000)); // CMP 5,5
    vecs.push_back(mk(0, 16'h0009, 5'd15, 5'd15, 5'd0,  0, 0, 4'b0100, 4'b0000, 16'h0005, 5'b01000)); // NOP hold
    vecs.push_back(mk(0, 16'h1234, 5'd16, 5'd15, 5'd0,  0, 0, 4'b1101, 4'b0000, 16'h0005, 5'b00000)); // no write
    vecs.push_back(mk(0, 16'h00F0, 5'd2,  5'd0,  5'd0,  0, 0, 4'b1101, 4'b0000, 16'h0005, 5'b00000)); // MOV r2
    vecs.push_back(mk(0, 16'h0000, 5'd15, 5'd15, 5'd2,  0, 1, 4'b0010, 4'b0000, 16'h00F5, 5'b00000)); // OR bus B
    vecs.push_back(mk(0, 16'h0000, 5'd15, 5'd15, 5'd2,  0, 1, 4'b1001, 4'b0000, 16'h0005, 5'b00000)); // SUB bus B
    vecs.push_back(mk(0, 16'hFFFF, 5'd15, 5'd15, 5'd0,  1, 0, 4'b0111, 4'b0000, 16'h0005, 5'b00001)); // ADDC
    vecs.push_back(mk(0, 16'h0005, 5'd15, 5'd15, 5'd0,  1, 0, 4'b1010, 4'b0000, 16'hFFFF, 5'b01001)); // SUBC
    vecs.push_back(mk(0, 16'h8000, 5'd15, 5'd15, 5'd0,  0, 0, 4'b0110, 4'b0000, 16'h7FFF, 5'b00001)); // ADDU
    vecs.push_back(mk(0, 16'h0000, 5'd15, 5'd15, 5'd15, 0, 1, 4'b0101, 4'b0000, 16'hFFFE, 5'b10100)); // r15+r15
    vecs.push_back(mk(0, 16'h0003, 5'd15, 5'd16, 5'd0,  0, 0, 4'b0101, 4'b0000, 16'h0003, 5'b00000)); // A off
    vecs.push_back(mk(0, 16'h0000, 5'd15, 5'd15, 5'd20, 0, 1, 4'b0010, 4'b0000, 16'h0003, 5'b00000)); // B off
    vecs.push_back(mk(0, 16'h8000, 5'd15, 5'd0,  5'd0,  0, 0, 4'b1101, 4'b0000, 16'h8000, 5'b10000)); // MOV
    vecs.push_back(mk(0, 16'h0001, 5'd15, 5'd15, 5'd0,  0, 0, 4'b1001, 4'b0000, 16'h7FFF, 5'b10100)); // SUB ovf
`ifdef ALU_SHIFT_EN
    vecs.push_back(mk(0, 16'h0001, 5'd15, 5'd15, 5'd0,  0, 0, 4'b1000, 4'b0000, 16'hFFFE, 5'b10000)); // LSH +1
    vecs.push_back(mk(0, 16'h0010, 5'd15, 5'd15, 5'd0,  0, 0, 4'b1000, 4'b0000, 16'h0000, 5'b01000)); // LSH -16
`else
    vecs.push_back(mk(0, 16'h0001, 5'd15, 5'd15, 5'd0,  0, 0, 4'b1000, 4'b0000, 16'h7FFF, 5'b10100)); // 1000 NOP
`endif
    vecs.push_back(mk(1, 16'hABCD, 5'd15, 5'd0,  5'd0,  0, 0, 4'b1101, 4'b0000, 16'h0000, 5'b00000)); // reset wins
    vecs.push_back(mk(0, 16'h0042, 5'd15, 5'd0,  5'd0,  0, 0, 4'b1101, 4'b0000, 16'h0042, 5'b00000)); // resume
    vecs.push_back(mk(0, 16'h0000, 5'd15, 5'd1,  5'd0,  0, 0, 4'b0101, 4'b0000, 16'h0000, 5'b01000)); // r1 cleared

    reset = 1'b1; immediate = '0; regEnables = 5'd16; buffAEnables = '0;
    buffBEnables = '0; Cin = 1'b0; regOrImmed = 1'b0; op = '0; exop = '0;
    repeat (50) @(posedge clock);
    #1 check("reset", 16'h0000, 5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset        = vecs[i].rst;
      immediate    = vecs[i].imm;
      regEnables   = vecs[i].regen;
      buffAEnables = vecs[i].aen;
      buffBEnables = vecs[i].ben;
      Cin          = vecs[i].cin;
      regOrImmed   = vecs[i].roi;
      op           = vecs[i].op;
      exop         = vecs[i].exop;
      @(posedge clock);
      #1 check($sformatf("vec%0d", i), vecs[i].exp_r15, vecs[i].exp_flags);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_reg_integration.md
Name: alu_reg_integration

Overview:
- Datapath core that pairs a 16 x 16-bit register file with a combinational 16-bit ALU and a registered 5-bit flag register.
- Two read buses (A, B) select source registers. Operand B is either bus B or a 16-bit immediate.
- The ALU result is written back to one selected register on the rising clock edge.
- Sits under the future control/decode unit, which drives all select and opcode inputs directly.

Parameters:
- WIDTH, 16, datapath and register width.
- NREGS, 16, number of registers (index width 4; select inputs carry one extra "disable" bit).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; clears all registers and flags.
- immediate  input  16  immediate operand.
- regEnables  input  5  write-back select. Values 0-15 write that register; 16-31 mean no write.
- buffAEnables  input  5  bus A source select. Values 0-15 drive that register; 16-31 drive 0.
- buffBEnables  input  5  bus B source select, same encoding as bus A.
- Cin  input  1  carry/borrow input for ADDC/SUBC.
- regOrImmed  input  1  operand B source: 1 = bus B, 0 = immediate.
- op  input  4  primary opcode.
- exop  input  4  extended opcode, used only when op==0000.
- flagsOutput  output  5  registered flags {N,Z,F,L,C} at bits [4:0].
- regOut15  output  16  current contents of r15, direct from the register.

Behaviour:
- Effective code: ec = (op==0000) ? exop : op.
- A = bus A value; B = regOrImmed ? bus B : immediate.
- Operations by ec:
  - 0001 AND
  - 0010 OR
  - 0011 XOR
  - 0101 ADD (signed)
  - 0110 ADDU
  - 0111 ADDC: A+B+Cin
  - 1001 SUB: A-B
  - 1010 SUBC: A-B-Cin
  - 1011 CMP: A-B, no write-back
  - 1101 MOV: result=B
  - all other codes: NOP, meaning no write-back and flags hold.
- Results are 16-bit and wrap modulo 2^16.
- Flags, all captured on the clock edge:
  - ADD/ADDC: C = carry out of bit 15; F = signed overflow; Z = result==0; N = result[15]; L = 0.
  - ADDU: as ADD, but F = 0.
  - SUB/SUBC/CMP: C = borrow; F = signed overflow; L = A<B unsigned; N = A<B signed; Z = A==B.
  - Logic ops and MOV: Z = result==0; N = result[15]; C = F = L = 0.
- Timing: reads and ALU are combinational. The write to the selected register and the flags update on the same rising edge, so latency is 1 cycle. regOut15 reflects the new r15 after that edge.
- When bus A, bus B and the write target are the same register, the old value is read and the new value is written (read-before-write).
- Reset, synchronous: at the edge with reset=1, all 16 registers and flagsOutput become 0, and any write-back in that cycle is suppressed.
- Reset deasserting mid-sequence: normal operation resumes at the next edge.
- All registers, including r0, are writable.

Optional Feature:
- Macro ALU_SHIFT_EN.
- When defined, ec=1000 is LSH: result = A shifted by the signed amount B[4:0].
  - Positive amounts shift left, zero-fill.
  - Negative amounts shift right logically.
  - An amount of -16 yields 0.
  - Flags: Z and N from the result; C, F, L = 0.
- When not defined, ec=1000 is a NOP.

Decomposition:
- Package alu_reg_pkg holds:
  - ec opcode constants (AND, OR, XOR, ADD, ADDU, ADDC, SUB, SUBC, CMP, MOV, LSH);
  - flag bit indices FLAG_C=0, FLAG_L=1, FLAG_F=2, FLAG_Z=3, FLAG_N=4;
  - the select-disable threshold (16).
- One sub-module, alu_core: purely combinational (A, B, Cin, ec) -> (result, flags_next, write_valid, flags_valid).
- The register file and flag register remain in the top.

Test Plan:
- Reset held for 50 cycles -> regOut15=0, flagsOutput=0.
- After reset: immediate=1, regEnables=15, buffAEnables=15, regOrImmed=0, op=0011 (XOR), exop=0 -> regOut15=0x0001 after one edge; flags Z=0, N=0.
- Load r1=0xFFFF (op=0000, exop=1101, regOrImmed=0, imm=0xFFFF, regEnables=1). Then ADD r15=r1+imm 1 (op=0101) -> regOut15=0x0000, C=1, Z=1, F=0.
- Signed overflow: r15=0x7FFF, ADD immediate 1 -> regOut15=0x8000, F=1, N=1, C=0.
- CMP with r15=5, immediate=7 (op=1011) -> r15 unchanged, L=1, N=1, Z=0. With immediate=5 instead -> Z=1, L=0.
- Write disable and reset: regEnables=16, any op -> no register changes. Reset asserted while regEnables=15 and a valid op -> r15=0, flags=0.
